// File: rtl/sdram_read_arbiter.sv
// Two-master read arbiter for the SDRAM controller's Avalon-MM read port.
// Round-robin with a streak limit; an ID FIFO routes each returned beat to its issuer.
`timescale 1ns/1ps
module sdram_read_arbiter #(
    parameter int unsigned ADDR_W          = 25,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned BURST_LIMIT     = 8
) (
    input  logic              Clk,
    input  logic              Reset_h,

    input  logic              r0_read,
    input  logic [ADDR_W-1:0] r0_address,
    output logic              r0_waitrequest,
    output logic [DATA_W-1:0] r0_readdata,
    output logic              r0_readdatavalid,

    input  logic              r1_read,
    input  logic [ADDR_W-1:0] r1_address,
    output logic              r1_waitrequest,
    output logic [DATA_W-1:0] r1_readdata,
    output logic              r1_readdatavalid,

    output logic              m_cs,
    output logic              m_read_n,
    output logic [ADDR_W-1:0] m_address,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,

    output logic [2:0]        outstanding,
    output logic              err_orphan
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned STK_W = $clog2(BURST_LIMIT + 1);

    typedef enum logic [1:0] {
        ARB_OPEN  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic              id_mem [MAX_OUTSTANDING];
    logic              last_grant_q;
    logic [STK_W-1:0]  streak_q;
    logic              err_orphan_q;

    logic full, empty, gnt_valid, gnt_id, accept, pop, orphan, head_id;

    // Grant selection, command path and beat routing.
    always_comb begin
        state_d          = ARB_OPEN;
        gnt_valid        = 1'b0;
        gnt_id           = 1'b0;
        full             = (count_q == CNT_W'(MAX_OUTSTANDING));
        empty            = (count_q == '0);
        head_id          = id_mem[rd_ptr_q];

        if (!Reset_h && !full) begin
            if (state_q == ARB_LOCK0) begin
                // A locked owner that drops read loses the lock without a grant.
                gnt_valid = r0_read;
                gnt_id    = 1'b0;
            end else if (state_q == ARB_LOCK1) begin
                gnt_valid = r1_read;
                gnt_id    = 1'b1;
            end else if (r0_read && r1_read) begin
                gnt_valid = 1'b1;
                if (last_grant_q && (streak_q == '0)) begin
                    gnt_id = 1'b0;
                end else if (streak_q < STK_W'(BURST_LIMIT)) begin
                    gnt_id = last_grant_q;
                end else begin
                    gnt_id = ~last_grant_q;
                end
            end else if (r0_read) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (r1_read) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end

        accept = gnt_valid && !m_waitrequest;
        if (gnt_valid && m_waitrequest) begin
            state_d = gnt_id ? ARB_LOCK1 : ARB_LOCK0;
        end

        pop    = !Reset_h && m_readdatavalid && !empty;
        orphan = !Reset_h && m_readdatavalid && empty;

        m_cs             = gnt_valid;
        m_read_n         = ~gnt_valid;
        m_address        = gnt_id ? r1_address : r0_address;
        r0_waitrequest   = (gnt_valid && !gnt_id) ? m_waitrequest : 1'b1;
        r1_waitrequest   = (gnt_valid &&  gnt_id) ? m_waitrequest : 1'b1;
        r0_readdatavalid = pop && !head_id;
        r1_readdatavalid = pop &&  head_id;
    end

    assign r0_readdata = m_readdata;
    assign r1_readdata = m_readdata;
    assign outstanding = 3'(count_q);
    assign err_orphan  = err_orphan_q;

    // Arbitration state, FIFO pointers and occupancy.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state_q      <= ARB_OPEN;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_grant_q <= 1'b1;
            streak_q     <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_ptr_q     <= wr_ptr_q + PTR_W'(1);
                last_grant_q <= gnt_id;
                if (gnt_id == last_grant_q) begin
                    streak_q <= (streak_q == STK_W'(BURST_LIMIT)) ? streak_q : streak_q + STK_W'(1);
                end else begin
                    streak_q <= STK_W'(1);
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (accept && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !accept) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (orphan) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

    // ID storage; contents are don't-care until written.
    always_ff @(posedge Clk) begin
        if (accept) begin
            id_mem[wr_ptr_q] <= gnt_id;
        end
    end

endmodule
